// File: rtl/cpu_clk_gen_if.sv
// Control and status bundle between the CPU clock generator and its host.
// The host drives mode, divisors and the step button; the generator drives clocks and counters.
interface cpu_clk_gen_if #(
    parameter int CNT_W = 32,
    parameter int DIV_W = 8,
    parameter int CYC_W = 32
);
    logic [1:0]       mode;
    logic [DIV_W-1:0] div_fast;
    logic [DIV_W-1:0] div_slow;
    logic             step;
    logic [CNT_W-1:0] clkdiv;
    logic             clk_cpu;
    logic             cpu_ce;
    logic [CYC_W-1:0] cyc_cnt;
    logic             stopped;

    modport master (
        output mode, div_fast, div_slow, step,
        input  clkdiv, clk_cpu, cpu_ce, cyc_cnt, stopped
    );

    modport slave (
        input  mode, div_fast, div_slow, step,
        output clkdiv, clk_cpu, cpu_ce, cyc_cnt, stopped
    );
endinterface

// File: rtl/cpu_clk_gen.sv
// CPU clock generator: free-running divide counter plus a run/stop/single-step
// FSM producing a registered, glitch-free CPU clock with a rising-edge enable.
module cpu_clk_gen #(
    parameter int CNT_W = 32,
    parameter int DIV_W = 8,
    parameter int CYC_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_clk_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        STOP    = 3'd0,
        RUN_HI  = 3'd1,
        RUN_LO  = 3'd2,
        STEP_HI = 3'd3,
        STEP_LO = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [DIV_W-1:0] ph_cnt_q;
    logic [DIV_W-1:0] act_div_q;
    logic [DIV_W-1:0] div_sel;
    logic             step_q;
    logic             step_rise;
    logic             run_mode;
    logic             step_mode;
    logic             phase_end;
    logic             phase_start;
    logic             hi_nxt;
    logic             rise_nxt;

    logic [CNT_W-1:0] clkdiv_q;
    logic             clk_cpu_q;
    logic             cpu_ce_q;
    logic [CYC_W-1:0] cyc_cnt_q;
    logic             stopped_q;

    assign step_rise = bus.step & ~step_q;
    assign run_mode  = ~bus.mode[1];
    assign step_mode = (bus.mode == 2'b11);
    assign phase_end = (ph_cnt_q == act_div_q);
    assign div_sel   = (bus.mode == 2'b00) ? bus.div_fast : bus.div_slow;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            STOP: begin
                if (run_mode)
                    state_nxt = RUN_HI;
                else if (step_mode && step_rise)
                    state_nxt = STEP_HI;
            end
            RUN_HI:  if (phase_end) state_nxt = RUN_LO;
            RUN_LO:  if (phase_end) state_nxt = run_mode ? RUN_HI : STOP;
            STEP_HI: if (phase_end) state_nxt = STEP_LO;
            STEP_LO: if (phase_end) state_nxt = STOP;
            default: state_nxt = STOP;
        endcase
    end

    // Every non-STOP state is exactly one phase, so any move into one starts a phase.
    always_comb begin
        phase_start = (state_nxt != state_q) && (state_nxt != STOP);
        hi_nxt      = (state_nxt == RUN_HI) || (state_nxt == STEP_HI);
        rise_nxt    = phase_start && hi_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STOP;
            ph_cnt_q  <= '0;
            step_q    <= 1'b0;
            clkdiv_q  <= '0;
            clk_cpu_q <= 1'b0;
            cpu_ce_q  <= 1'b0;
            cyc_cnt_q <= '0;
            stopped_q <= 1'b1;
        end else begin
            state_q  <= state_nxt;
            step_q   <= bus.step;
            clkdiv_q <= clkdiv_q + CNT_W'(1);
            if (phase_start || state_nxt == STOP)
                ph_cnt_q <= '0;
            else
                ph_cnt_q <= ph_cnt_q + DIV_W'(1);
            clk_cpu_q <= hi_nxt;
            cpu_ce_q  <= rise_nxt;
            if (rise_nxt)
                cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
            stopped_q <= (state_nxt == STOP);
        end
    end

    // Divisor is sampled only at phase start so mid-phase edits wait for the next phase.
    always_ff @(posedge clk) begin
        if (!rst && phase_start)
            act_div_q <= div_sel;
    end

    assign bus.clkdiv  = clkdiv_q;
    assign bus.clk_cpu = clk_cpu_q;
    assign bus.cpu_ce  = cpu_ce_q;
    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.stopped = stopped_q;

endmodule
